// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared PRGA state encoding, character bounds and message length
package rc4_pkg;

  // PRGA sequencer states; one byte walks WT_SI..NEXT, RD_SI only opens a run
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RD_SI  = 4'd1,
    ST_WT_SI  = 4'd2,
    ST_CAP_SI = 4'd3,
    ST_WT_SJ  = 4'd4,
    ST_CAP_SJ = 4'd5,
    ST_WR_SJ  = 4'd6,
    ST_RD_F   = 4'd7,
    ST_WT_F   = 4'd8,
    ST_CAP_F  = 4'd9,
    ST_NEXT   = 4'd10,
    ST_DONE   = 4'd11
  } prga_state_t;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam int DEFAULT_MSG_LENGTH = 32;

  // Accepted plaintext alphabet: lowercase letters and space
  function automatic logic is_text_char(input logic [7:0] b);
    return ((b >= CHAR_LO) && (b <= CHAR_HI)) || (b == CHAR_SPACE);
  endfunction

endpackage

// File: rtl/trap_edge.sv
// rtl/trap_edge.sv - rising-edge detector for a level input
module trap_edge
  import rc4_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_sig,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level so a low-to-high step can be seen
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/rc4_keystream_decryptor.sv
// rtl/rc4_keystream_decryptor.sv - RC4 PRGA keystream and message decrypt (option macro: RC4_VALIDATE_EN)
module rc4_keystream_decryptor
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = 8,
  parameter int RAM_LENGTH = 8,
  parameter int MSG_LENGTH = DEFAULT_MSG_LENGTH,
  parameter int MSG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_finished,
  input  logic [RAM_WIDTH-1:0]  i_s_ram_out,
  output logic [RAM_LENGTH-1:0] o_s_address,
  output logic [RAM_WIDTH-1:0]  o_s_ram_in,
  output logic                  o_s_write_en,
  output logic [MSG_ADDR_W-1:0] o_enc_address,
  input  logic [RAM_WIDTH-1:0]  i_enc_rom_out,
  output logic [MSG_ADDR_W-1:0] o_dec_address,
  output logic [RAM_WIDTH-1:0]  o_dec_ram_in,
  output logic                  o_dec_write_en,
  output logic                  o_invalid
);

  localparam logic [MSG_ADDR_W-1:0] LAST_K = MSG_ADDR_W'(MSG_LENGTH - 1);

  prga_state_t           r_state;
  logic [RAM_LENGTH-1:0] r_i;
  logic [RAM_LENGTH-1:0] r_j;
  logic [MSG_ADDR_W-1:0] r_k;
  logic [RAM_WIDTH-1:0]  r_si;
  logic [RAM_WIDTH-1:0]  r_sj;
  logic                  r_finished;
  logic [RAM_LENGTH-1:0] r_s_address;
  logic [RAM_WIDTH-1:0]  r_s_ram_in;
  logic                  r_s_write_en;
  logic [MSG_ADDR_W-1:0] r_enc_address;
  logic [MSG_ADDR_W-1:0] r_dec_address;
  logic [RAM_WIDTH-1:0]  r_dec_ram_in;
  logic                  r_dec_write_en;

  logic                  w_start_rise;
  logic [RAM_LENGTH-1:0] w_j_next;
  logic [RAM_LENGTH-1:0] w_f_addr;
  logic [RAM_LENGTH-1:0] w_i_next;
  logic [RAM_WIDTH-1:0]  w_plain;
  logic                  w_plain_ok;

  trap_edge u_start_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_sig   (i_start),
    .o_rise  (w_start_rise)
  );

  // j advances by the S[i] value arriving this cycle, not the registered copy
  assign w_j_next = r_j + RAM_LENGTH'(i_s_ram_out);
  assign w_f_addr = RAM_LENGTH'(r_si + r_sj);
  assign w_i_next = r_i + 1'b1;
  assign w_plain  = i_s_ram_out ^ i_enc_rom_out;

`ifdef RC4_VALIDATE_EN
  logic r_invalid;
  assign w_plain_ok = is_text_char(8'(w_plain));
  assign o_invalid  = r_invalid;
`else
  assign w_plain_ok = 1'b1;
  assign o_invalid  = 1'b0;
`endif

  // PRGA sequencer: every memory strobe and status flag is registered here
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_i            <= '0;
      r_j            <= '0;
      r_k            <= '0;
      r_si           <= '0;
      r_sj           <= '0;
      r_finished     <= 1'b0;
      r_s_address    <= '0;
      r_s_ram_in     <= '0;
      r_s_write_en   <= 1'b0;
      r_enc_address  <= '0;
      r_dec_address  <= '0;
      r_dec_ram_in   <= '0;
      r_dec_write_en <= 1'b0;
`ifdef RC4_VALIDATE_EN
      r_invalid      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_s_write_en   <= 1'b0;
          r_dec_write_en <= 1'b0;
          if (w_start_rise) begin
            r_i        <= RAM_LENGTH'(1);
            r_j        <= '0;
            r_k        <= '0;
            r_finished <= 1'b0;
`ifdef RC4_VALIDATE_EN
            r_invalid  <= 1'b0;
`endif
            r_state    <= ST_RD_SI;
          end
        end
        ST_RD_SI: begin
          r_s_address  <= r_i;
          r_s_write_en <= 1'b0;
          r_state      <= ST_WT_SI;
        end
        ST_WT_SI: begin
          r_state <= ST_CAP_SI;
        end
        ST_CAP_SI: begin
          r_si        <= i_s_ram_out;
          r_j         <= w_j_next;
          r_s_address <= w_j_next;
          r_state     <= ST_WT_SJ;
        end
        ST_WT_SJ: begin
          r_state <= ST_CAP_SJ;
        end
        ST_CAP_SJ: begin
          r_sj         <= i_s_ram_out;
          r_s_address  <= r_i;
          r_s_ram_in   <= i_s_ram_out;
          r_s_write_en <= 1'b1;
          r_state      <= ST_WR_SJ;
        end
        ST_WR_SJ: begin
          // When i==j this second write lands on the same entry with the same value
          r_s_address  <= r_j;
          r_s_ram_in   <= r_si;
          r_s_write_en <= 1'b1;
          r_state      <= ST_RD_F;
        end
        ST_RD_F: begin
          r_s_address   <= w_f_addr;
          r_s_write_en  <= 1'b0;
          r_enc_address <= r_k;
          r_state       <= ST_WT_F;
        end
        ST_WT_F: begin
          r_state <= ST_CAP_F;
        end
        ST_CAP_F: begin
          if (w_plain_ok) begin
            r_dec_address  <= r_k;
            r_dec_ram_in   <= w_plain;
            r_dec_write_en <= 1'b1;
            r_state        <= ST_NEXT;
          end else begin
            r_finished <= 1'b1;
`ifdef RC4_VALIDATE_EN
            r_invalid  <= 1'b1;
`endif
            r_state    <= ST_DONE;
          end
        end
        ST_NEXT: begin
          // Also issues the next byte's S[i] read so each byte costs nine clocks
          r_dec_write_en <= 1'b0;
          if (r_k == LAST_K) begin
            r_finished <= 1'b1;
            r_state    <= ST_DONE;
          end else begin
            r_k          <= r_k + 1'b1;
            r_i          <= w_i_next;
            r_s_address  <= w_i_next;
            r_s_write_en <= 1'b0;
            r_state      <= ST_WT_SI;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_finished     = r_finished;
  assign o_s_address    = r_s_address;
  assign o_s_ram_in     = r_s_ram_in;
  assign o_s_write_en   = r_s_write_en;
  assign o_enc_address  = r_enc_address;
  assign o_dec_address  = r_dec_address;
  assign o_dec_ram_in   = r_dec_ram_in;
  assign o_dec_write_en = r_dec_write_en;

endmodule

// File: tb/tb_rc4_keystream_decryptor.sv
// tb/tb_rc4_keystream_decryptor.sv - directed bench for the RC4 PRGA decryptor
module tb_rc4_keystream_decryptor;

  logic clk;

  // Instance A: two-byte message
  logic       a_reset, a_start, a_finished, a_s_we, a_dec_we, a_invalid;
  logic [7:0] a_s_addr, a_s_din, a_s_q, a_enc_q, a_dec_din;
  logic [4:0] a_enc_addr, a_dec_addr;
  logic       a_s_load;
  logic [7:0] a_s_mem [256];
  logic [7:0] a_enc [32];
  logic [7:0] a_dec [32];
  int         a_we_cnt;

  // Instance B: 32-byte message
  logic       b_reset, b_start, b_finished, b_s_we, b_dec_we, b_invalid;
  logic [7:0] b_s_addr, b_s_din, b_s_q, b_enc_q, b_dec_din;
  logic [4:0] b_enc_addr, b_dec_addr;
  logic       b_s_load;
  logic [7:0] b_s_mem [256];
  logic [7:0] b_enc [32];
  logic [7:0] b_dec [32];
  logic [7:0] b_ref [32];
  int         b_we_cnt;
  logic       b_we_dbl, b_we_prev;

  int vectors;
  int miscompares;

  rc4_keystream_decryptor #(.MSG_LENGTH(2)) dut_a (
    .i_clk          (clk),
    .i_reset        (a_reset),
    .i_start        (a_start),
    .o_finished     (a_finished),
    .i_s_ram_out    (a_s_q),
    .o_s_address    (a_s_addr),
    .o_s_ram_in     (a_s_din),
    .o_s_write_en   (a_s_we),
    .o_enc_address  (a_enc_addr),
    .i_enc_rom_out  (a_enc_q),
    .o_dec_address  (a_dec_addr),
    .o_dec_ram_in   (a_dec_din),
    .o_dec_write_en (a_dec_we),
    .o_invalid      (a_invalid)
  );

  rc4_keystream_decryptor #(.MSG_LENGTH(32)) dut_b (
    .i_clk          (clk),
    .i_reset        (b_reset),
    .i_start        (b_start),
    .o_finished     (b_finished),
    .i_s_ram_out    (b_s_q),
    .o_s_address    (b_s_addr),
    .o_s_ram_in     (b_s_din),
    .o_s_write_en   (b_s_we),
    .o_enc_address  (b_enc_addr),
    .i_enc_rom_out  (b_enc_q),
    .o_dec_address  (b_dec_addr),
    .o_dec_ram_in   (b_dec_din),
    .o_dec_write_en (b_dec_we),
    .o_invalid      (b_invalid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read memories for instance A; load puts S back to identity
  always @(posedge clk) begin
    if (a_s_load) begin
      for (int n = 0; n < 256; n++) a_s_mem[n] <= 8'(n);
      for (int n = 0; n < 32; n++) a_dec[n] <= 8'hEE;
      a_we_cnt <= 0;
    end else begin
      if (a_s_we) a_s_mem[a_s_addr] <= a_s_din;
      if (a_dec_we) begin
        a_dec[a_dec_addr] <= a_dec_din;
        a_we_cnt <= a_we_cnt + 1;
      end
    end
    a_s_q   <= a_s_mem[a_s_addr];
    a_enc_q <= a_enc[a_enc_addr];
  end

  // Synchronous-read memories for instance B plus write-pulse bookkeeping
  always @(posedge clk) begin
    if (b_s_load) begin
      for (int n = 0; n < 256; n++) b_s_mem[n] <= 8'(n);
      for (int n = 0; n < 32; n++) b_dec[n] <= 8'hEE;
      b_we_cnt <= 0;
      b_we_dbl <= 1'b0;
    end else begin
      if (b_s_we) b_s_mem[b_s_addr] <= b_s_din;
      if (b_dec_we) begin
        b_dec[b_dec_addr] <= b_dec_din;
        b_we_cnt <= b_we_cnt + 1;
        if (b_we_prev) b_we_dbl <= 1'b1;
      end
    end
    b_we_prev <= b_dec_we;
    b_s_q     <= b_s_mem[b_s_addr];
    b_enc_q   <= b_enc[b_enc_addr];
  end

  task automatic load_a();
    @(negedge clk); a_s_load = 1'b1;
    @(negedge clk); a_s_load = 1'b0;
  endtask

  task automatic load_b();
    @(negedge clk); b_s_load = 1'b1;
    @(negedge clk); b_s_load = 1'b0;
  endtask

  // Launch a run on A and wait (bounded) for finished
  task automatic run_a();
    int cyc;
    a_start = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!a_finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (a_finished !== 1'b1) begin
      $display("FAIL run_a_timeout: finished=%b after %0d cycles, required 1", a_finished, cyc);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    a_reset = 1'b1; b_reset = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a_finished, a_s_addr, a_s_din, a_s_we, a_enc_addr, a_dec_addr, a_dec_din, a_dec_we, a_invalid} !== '0) begin
      $display("FAIL reset_a: outputs=%h required 0",
               {a_finished, a_s_addr, a_s_din, a_s_we, a_enc_addr, a_dec_addr, a_dec_din, a_dec_we, a_invalid});
      miscompares++;
    end
    vectors++;
    if ({b_finished, b_s_addr, b_s_din, b_s_we, b_enc_addr, b_dec_addr, b_dec_din, b_dec_we, b_invalid} !== '0) begin
      $display("FAIL reset_b: outputs=%h required 0",
               {b_finished, b_s_addr, b_s_din, b_s_we, b_enc_addr, b_dec_addr, b_dec_din, b_dec_we, b_invalid});
      miscompares++;
    end
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);
  endtask

  // Expected after a two-byte run from identity: S[2]=3, S[3]=2
  task automatic check_two_byte_result(input string tag);
    logic [7:0] exp;
    vectors++;
    if (a_dec[0] !== 8'h41) begin
      $display("FAIL %s_dec0: got %h required 41", tag, a_dec[0]); miscompares++;
    end
    vectors++;
    if (a_dec[1] !== 8'h42) begin
      $display("FAIL %s_dec1: got %h required 42", tag, a_dec[1]); miscompares++;
    end
    vectors++;
    if (a_we_cnt !== 2) begin
      $display("FAIL %s_we_count: got %0d required 2", tag, a_we_cnt); miscompares++;
    end
    for (int n = 0; n < 256; n++) begin
      exp = (n == 2) ? 8'd3 : (n == 3) ? 8'd2 : 8'(n);
      vectors++;
      if (a_s_mem[n] !== exp) begin
        $display("FAIL %s_s[%0d]: got %h required %h", tag, n, a_s_mem[n], exp); miscompares++;
      end
    end
  endtask

  task automatic test_basic_decrypt();
    a_enc[0] = 8'h43; a_enc[1] = 8'h47;
    load_a();
    run_a();
    check_two_byte_result("basic");
    vectors++;
    if (a_invalid !== 1'b0) begin
      $display("FAIL basic_invalid: got %b required 0", a_invalid); miscompares++;
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    bit seen;
    load_a();
    a_start = 1'b0;
    @(negedge clk);
    a_start = 1'b1;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (a_s_we && a_s_addr == 8'd2) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      $display("FAIL midrun_wr_sj_seen: not found in %0d cycles, required within 40", cyc); miscompares++;
    end
    a_reset = 1'b1;
    a_start = 1'b0;
    @(negedge clk);
    vectors++;
    if ({a_finished, a_s_addr, a_s_din, a_s_we, a_enc_addr, a_dec_addr, a_dec_din, a_dec_we, a_invalid} !== '0) begin
      $display("FAIL midrun_reset_outputs: outputs=%h required 0",
               {a_finished, a_s_addr, a_s_din, a_s_we, a_enc_addr, a_dec_addr, a_dec_din, a_dec_we, a_invalid});
      miscompares++;
    end
    a_reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a_finished, a_s_addr, a_s_we, a_dec_we} !== '0) begin
      $display("FAIL midrun_idle_quiet: outputs=%h required 0", {a_finished, a_s_addr, a_s_we, a_dec_we});
      miscompares++;
    end
    load_a();
    run_a();
    check_two_byte_result("rerun");
  endtask

  task automatic test_run_length();
    int n;
    for (int m = 0; m < 32; m++) b_enc[m] = 8'h00;
    load_b();
    b_start = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    vectors++;
    if (b_finished !== 1'b0) begin
      $display("FAIL len_finished_clear: got %b required 0", b_finished); miscompares++;
    end
    @(negedge clk);
    vectors++;
    if (b_s_addr !== 8'd1) begin
      $display("FAIL len_first_read: s_address=%h required 01", b_s_addr); miscompares++;
    end
    n = 0;
    while (!b_finished && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n !== 288) begin
      $display("FAIL len_cycles: got %0d required 288", n); miscompares++;
    end
    vectors++;
    if (b_we_cnt !== 32) begin
      $display("FAIL len_we_count: got %0d required 32", b_we_cnt); miscompares++;
    end
    vectors++;
    if (b_we_dbl !== 1'b0) begin
      $display("FAIL len_we_single: back-to-back enable=%b required 0", b_we_dbl); miscompares++;
    end
    for (int m = 0; m < 32; m++) b_ref[m] = b_dec[m];
  endtask

  task automatic test_start_ignored();
    int n, t_addr;
    load_b();
    b_start = 1'b0;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    n = 0;
    t_addr = -1;
    while (!b_finished && n < 400) begin
      if (n >= 1 && n < 250) b_start = ~b_start;
      else if (n >= 250) b_start = 1'b0;
      @(negedge clk);
      n++;
      if (t_addr < 0 && b_s_addr == 8'd1) t_addr = n;
    end
    b_start = 1'b0;
    vectors++;
    if (t_addr !== 1) begin
      $display("FAIL ign_first_read: seen at %0d required 1", t_addr); miscompares++;
    end
    vectors++;
    if (n - t_addr !== 288) begin
      $display("FAIL ign_cycles: got %0d required 288", n - t_addr); miscompares++;
    end
    vectors++;
    if (b_we_cnt !== 32) begin
      $display("FAIL ign_we_count: got %0d required 32", b_we_cnt); miscompares++;
    end
    for (int m = 0; m < 32; m++) begin
      vectors++;
      if (b_dec[m] !== b_ref[m]) begin
        $display("FAIL ign_dec[%0d]: got %h required %h", m, b_dec[m], b_ref[m]); miscompares++;
      end
    end
  endtask

`ifdef RC4_VALIDATE_EN
  task automatic test_validate_reject(input logic [7:0] enc0, input string tag);
    a_enc[0] = enc0; a_enc[1] = 8'h64;
    load_a();
    run_a();
    vectors++;
    if (a_invalid !== 1'b1) begin
      $display("FAIL %s_invalid: got %b required 1", tag, a_invalid); miscompares++;
    end
    vectors++;
    if (a_we_cnt !== 0) begin
      $display("FAIL %s_no_write: writes=%0d required 0", tag, a_we_cnt); miscompares++;
    end
    vectors++;
    if (a_dec[0] !== 8'hEE) begin
      $display("FAIL %s_dec0_untouched: got %h required ee", tag, a_dec[0]); miscompares++;
    end
  endtask

  task automatic test_validate_space();
    a_enc[0] = 8'h22; a_enc[1] = 8'h64;
    load_a();
    run_a();
    vectors++;
    if (a_invalid !== 1'b0) begin
      $display("FAIL space_invalid: got %b required 0", a_invalid); miscompares++;
    end
    vectors++;
    if (a_dec[0] !== 8'h20) begin
      $display("FAIL space_dec0: got %h required 20", a_dec[0]); miscompares++;
    end
    vectors++;
    if (a_dec[1] !== 8'h61) begin
      $display("FAIL space_dec1: got %h required 61", a_dec[1]); miscompares++;
    end
    vectors++;
    if (a_we_cnt !== 2) begin
      $display("FAIL space_we_count: got %0d required 2", a_we_cnt); miscompares++;
    end
  endtask
`else
  task automatic test_no_validate();
    a_enc[0] = 8'h00; a_enc[1] = 8'h47;
    load_a();
    run_a();
    vectors++;
    if (a_dec[0] !== 8'h02) begin
      $display("FAIL noval_dec0: got %h required 02", a_dec[0]); miscompares++;
    end
    vectors++;
    if (a_dec[1] !== 8'h42) begin
      $display("FAIL noval_dec1: got %h required 42", a_dec[1]); miscompares++;
    end
    vectors++;
    if (a_invalid !== 1'b0) begin
      $display("FAIL noval_invalid: got %b required 0", a_invalid); miscompares++;
    end
  endtask
`endif

  initial begin
    vectors = 0;
    miscompares = 0;
    a_reset = 1'b1; b_reset = 1'b1;
    a_start = 1'b0; b_start = 1'b0;
    a_s_load = 1'b0; b_s_load = 1'b0;
    for (int m = 0; m < 32; m++) begin
      a_enc[m] = 8'h00;
      b_enc[m] = 8'h00;
    end
    test_reset();
`ifdef RC4_VALIDATE_EN
    test_validate_reject(8'h00, "nonprint");
    test_validate_reject(8'h62, "backtick");
    test_validate_space();
`else
    test_basic_decrypt();
    test_reset_mid_run();
    test_run_length();
    test_start_ignored();
    test_no_validate();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
